// File: rtl/imem_boot_sequencer_if.sv
// rtl/imem_boot_sequencer_if.sv - instruction stream in, imem write port and run enable out
interface imem_boot_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] addr;
  logic              wEn;
  logic [DATA_W-1:0] wDat;
  logic              working;

  modport master (
    input  s_valid, s_data, s_last,
    output s_ready, addr, wEn, wDat, working
  );

  modport slave (
    output s_valid, s_data, s_last,
    input  s_ready, addr, wEn, wDat, working
  );
endinterface

// File: rtl/imem_boot_sequencer.sv
// rtl/imem_boot_sequencer.sv - loads a program into imem then runs the processor; optional IMEM_SEQ_CHECKSUM_EN
module imem_boot_sequencer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  imem_boot_sequencer_if.master bus,
  input  logic                  start,
  input  logic [CNT_W-1:0]      run_cycles,
  input  logic                  abort,
  input  logic                  clear,
  output logic [ADDR_W:0]       load_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overflow,
  output logic [DATA_W-1:0]     checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic                working_q, working_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                unbounded_q, unbounded_d;

  logic full;
  logic accept;
  logic clear_eff;
  logic s_ready_w;

  // load_count tops out at exactly DEPTH, so its MSB alone means full
  assign full      = load_count_q[ADDR_W];
  assign s_ready_w = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !full;
  assign accept    = bus.s_valid && s_ready_w;
  assign clear_eff = clear && (state_q != S_RUN);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wen_d        = accept;
    wdat_d       = wdat_q;
    load_count_d = load_count_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    unbounded_d  = unbounded_q;

    if (accept) begin
      addr_d       = load_count_q[ADDR_W-1:0];
      wdat_d       = bus.s_data;
      load_count_d = load_count_q + (ADDR_W+1)'(1);
    end
    if (full && bus.s_valid) begin
      err_d = 1'b1;
    end

    case (state_q)
      // an accept beats start here, otherwise wEn and working could overlap
      S_IDLE: begin
        if (accept) begin
          state_d = (bus.s_last || load_count_q == LAST_SLOT) ? S_WAIT_START : S_LOAD;
        end else if (start) begin
          state_d     = S_RUN;
          cnt_d       = run_cycles;
          unbounded_d = (run_cycles == '0);
        end
      end
      S_LOAD: begin
        if (accept && (bus.s_last || load_count_q == LAST_SLOT)) begin
          state_d = S_WAIT_START;
        end
      end
      S_WAIT_START, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          cnt_d       = run_cycles;
          unbounded_d = (run_cycles == '0);
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (abort) begin
          state_d = S_DONE;
        end else if (!unbounded_q && cnt_q <= CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // the write launched by a same-cycle accept still goes out
    if (clear_eff) begin
      state_d      = S_IDLE;
      load_count_d = '0;
      err_d        = 1'b0;
    end
  end

  assign working_d = (state_d == S_RUN);
  assign busy_d    = (state_d == S_LOAD) || (state_d == S_RUN);
  assign done_d    = (state_d == S_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdat_q       <= '0;
      working_q    <= 1'b0;
      load_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      unbounded_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdat_q       <= wdat_d;
      working_q    <= working_d;
      load_count_q <= load_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      unbounded_q  <= unbounded_d;
    end
  end

`ifdef IMEM_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (clear_eff) begin
      checksum_d = '0;
    end else if (accept) begin
      checksum_d = checksum_q ^ bus.s_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign bus.s_ready   = s_ready_w;
  assign bus.addr      = addr_q;
  assign bus.wEn       = wen_q;
  assign bus.wDat      = wdat_q;
  assign bus.working   = working_q;
  assign load_count    = load_count_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_overflow  = err_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// tb/tb_imem_boot_sequencer.sv - scoreboard bench for imem_boot_sequencer
module tb_imem_boot_sequencer;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [CW-1:0] run_cycles;
  logic          abort;
  logic          clear;
  logic [AW:0]   load_count;
  logic          busy;
  logic          done;
  logic          err_overflow;
  logic [DW-1:0] checksum;

  imem_boot_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_boot_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .start        (start),
    .run_cycles   (run_cycles),
    .abort        (abort),
    .clear        (clear),
    .load_count   (load_count),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow),
    .checksum     (checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int first; int len; } run_t;

  wr_t  wq[$];
  run_t rq[$];
  wr_t  we;
  run_t re;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int run_len = 0;
  int run_first = 0;

  int            m_count = 0;
  logic          m_err   = 1'b0;
  logic [DW-1:0] m_xor   = '0;
  logic [DW-1:0] prog[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_ck();
`ifdef IMEM_SEQ_CHECKSUM_EN
    return m_xor;
`else
    return '0;
`endif
  endfunction

  // monitor: writes and run windows are checked against what the stimulus queued
  always @(negedge clock) begin
    if (bus.wEn && bus.working) viol++;
    if (bus.wEn) begin
      if (wq.size() == 0) check("unexpected_write", 1, 0);
      else begin
        we = wq.pop_front();
        check("wr_addr", bus.addr, we.a);
        check("wr_data", bus.wDat, we.d);
      end
    end
    if (bus.working) begin
      if (run_len == 0) run_first = cyc;
      run_len++;
    end else if (run_len > 0) begin
      if (rq.size() == 0) check("unexpected_run", 1, 0);
      else begin
        re = rq.pop_front();
        check("run_first_cycle", run_first, re.first);
        check("run_length", run_len, re.len);
      end
      run_len = 0;
    end
  end

  task automatic model_write(input logic [DW-1:0] d);
    wr_t t;
    if (m_count < DEPTH) begin
      t.a = m_count[AW-1:0];
      t.d = d;
      wq.push_back(t);
      m_count++;
      m_xor ^= d;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic last, input int gap);
    repeat (gap) begin @(posedge clock); #1; end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    @(negedge clock);
    check("s_ready_offer", bus.s_ready, 1);
    @(posedge clock); #1;
    model_write(d);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // gap < 0 selects a random gap per word
  task automatic load_prog(input int gap, input logic use_last);
    for (int i = 0; i < prog.size(); i++) begin
      send_word(prog[i], use_last && (i == prog.size() - 1),
                (gap < 0) ? int'($urandom_range(0, 2)) : gap);
      if (i == 0 && prog.size() > 1) begin
        @(negedge clock);
        check("busy_in_load", busy, 1);
        @(posedge clock); #1;
      end
    end
    @(negedge clock);
    check("load_count", load_count, m_count);
    check("wait_start_not_ready", bus.s_ready, 0);
    check("wait_start_busy", busy, 0);
    check("wait_start_done", done, 0);
    check("load_err", err_overflow, m_err);
    check("load_checksum", checksum, exp_ck());
    @(posedge clock); #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (done) break;
    end
    check("done_reached", done, 1);
    check("done_busy", busy, 0);
    check("done_working", bus.working, 0);
    check("done_wen", bus.wEn, 0);
    @(posedge clock); #1;
  endtask

  // n == 0 runs unbounded and is stopped by abort during working cycle abort_after
  task automatic run_prog(input logic [CW-1:0] n, input int abort_after);
    run_t r;
    int c;
    run_cycles = n;
    start = 1'b1;
    c = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    run_cycles = $urandom();
    r.first = c + 1;
    r.len   = (n == 0) ? abort_after : int'(n);
    rq.push_back(r);
    if (n == 0) begin
      repeat (abort_after - 1) @(posedge clock);
      #1 abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
    end
    wait_done();
  endtask

  task automatic clear_seq(input logic with_start);
    clear = 1'b1;
    start = with_start;
    run_cycles = 5;
    @(posedge clock); #1;
    clear = 1'b0;
    start = 1'b0;
    m_count = 0;
    m_err = 1'b0;
    m_xor = '0;
    @(negedge clock);
    check("clr_load_count", load_count, 0);
    check("clr_err", err_overflow, 0);
    check("clr_s_ready", bus.s_ready, 1);
    check("clr_done", done, 0);
    check("clr_busy", busy, 0);
    check("clr_checksum", checksum, 0);
    @(posedge clock); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, bus.addr, 0);
    check({tag, "_wen"}, bus.wEn, 0);
    check({tag, "_wdat"}, bus.wDat, 0);
    check({tag, "_working"}, bus.working, 0);
    check({tag, "_load_count"}, load_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err_overflow, 0);
    check({tag, "_checksum"}, checksum, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    run_cycles = '0;
    abort = 1'b0;
    clear = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    #3;
    check_reset_values("reset");
    check("reset_s_ready", bus.s_ready, 1);
    @(posedge clock); @(posedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #1;

    prog = '{32'h1000001c, 32'h1001001e, 32'h10020020, 32'h10030022, 32'h10040024,
             32'h10050026, 32'h20100000, 32'h21320000, 32'h32450000};
    load_prog(-1, 1'b1);
    run_prog(9, 0);
    run_prog(2, 0);
    clear_seq(1'b0);
    run_prog(4, 0);
    clear_seq(1'b0);

    prog.delete();
    for (int i = 0; i < 6; i++) prog.push_back($urandom());
    load_prog(1, 1'b1);
    run_prog(CW'($urandom_range(1, 20)), 0);
    clear_seq(1'b0);

    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom());
    load_prog(-1, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data = $urandom();
    @(negedge clock);
    check("full_not_ready", bus.s_ready, 0);
    @(posedge clock); #1;
    bus.s_valid = 1'b0;
    m_err = 1'b1;
    @(negedge clock);
    check("overflow_err", err_overflow, 1);
    check("overflow_count", load_count, DEPTH);
    @(posedge clock); #1;
    clear_seq(1'b0);

    prog.delete();
    for (int i = 0; i < 3; i++) prog.push_back($urandom());
    load_prog(-1, 1'b1);
    run_prog(0, 5);
    clear_seq(1'b1);
    repeat (3) @(posedge clock);
    #1 check("clear_wins_no_run", bus.working, 0);

    for (int r = 0; r < 3; r++) begin
      prog.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) prog.push_back($urandom());
      load_prog(-1, 1'b1);
      if ($urandom_range(0, 1) == 1) run_prog(CW'($urandom_range(1, 12)), 0);
      else run_prog(0, int'($urandom_range(1, 8)));
      clear_seq(1'b0);
    end

    prog.delete();
    for (int i = 0; i < 2; i++) prog.push_back($urandom());
    load_prog(-1, 1'b1);
    begin
      run_t r;
      run_cycles = '0;
      start = 1'b1;
      r.first = cyc + 1;
      r.len = 3;
      rq.push_back(r);
      @(posedge clock); #1;
      start = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1 check_reset_values("async_reset");
      m_count = 0;
      m_err = 1'b0;
      m_xor = '0;
      @(posedge clock); #2;
      reset_n = 1'b1;
      @(negedge clock);
      check("post_reset_s_ready", bus.s_ready, 1);
      check("post_reset_working", bus.working, 0);
    end

    @(posedge clock); @(negedge clock);
    check("write_queue_empty", wq.size(), 0);
    check("run_queue_empty", rq.size(), 0);
    check("no_open_run", run_len, 0);
    check("wen_working_overlap", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
